// File: rtl/tablet_pkg.sv
// Shared state encoding, BCD sizing and target validation for the tablet fill controller.
package tablet_pkg;

  localparam int BCD_W   = 4;
  localparam int BCD_MAX = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_CHANGE,
    ST_SETTLE,
    ST_DONE
  } state_t;

  // A usable target has two legal BCD digits and is not zero.
  function automatic logic bcd_valid(input logic [BCD_W-1:0] tens,
                                     input logic [BCD_W-1:0] ones);
    return (tens <= BCD_W'(BCD_MAX)) && (ones <= BCD_W'(BCD_MAX)) &&
           ({tens, ones} != '0);
  endfunction

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD tablet counter; eq_target flags that the next increment lands on the target.
module bcd2_counter
  import tablet_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_inc,
  input  logic [BCD_W-1:0] i_tgt_tens,
  input  logic [BCD_W-1:0] i_tgt_ones,
  output logic [BCD_W-1:0] o_tens,
  output logic [BCD_W-1:0] o_ones,
  output logic             o_eq_target
);

  logic [BCD_W-1:0] r_tens;
  logic [BCD_W-1:0] r_ones;
  logic [BCD_W-1:0] w_next_tens;
  logic [BCD_W-1:0] w_next_ones;

  always_comb begin
    w_next_tens = r_tens;
    w_next_ones = r_ones + BCD_W'(1);
    if (r_ones == BCD_W'(BCD_MAX)) begin
      w_next_ones = '0;
      w_next_tens = r_tens + BCD_W'(1);
    end
  end

  // Compared against the incremented value so the FSM can leave FILL on the same edge.
  assign o_eq_target = ({w_next_tens, w_next_ones} == {i_tgt_tens, i_tgt_ones});

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tens <= '0;
      r_ones <= '0;
    end else if (i_clr) begin
      r_tens <= '0;
      r_ones <= '0;
    end else if (i_inc) begin
      r_tens <= w_next_tens;
      r_ones <= w_next_ones;
    end
  end

  assign o_tens = r_tens;
  assign o_ones = r_ones;

endmodule

// File: rtl/tablet_fill_ctrl.sv
// Per-bottle tablet fill controller: counts drops, gates tablets, strobes bottle change.
// Define TABLET_DEBOUNCE_EN to debounce the synchronised tablet sensor.
module tablet_fill_ctrl
  import tablet_pkg::*;
#(
  parameter int CHANGE_CYCLES   = 4,
  parameter int SETTLE_CYCLES   = 16,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_tablet,
  input  logic [BCD_W-1:0] i_target_tens,
  input  logic [BCD_W-1:0] i_target_ones,
  input  logic             i_pre_over,
  output logic [BCD_W-1:0] o_tab_tens,
  output logic [BCD_W-1:0] o_tab_ones,
  output logic             o_gate_open,
  output logic             o_change,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_spill
);

  // One interval-counter width covers the change, settle and debounce timers.
  localparam int LONG_CS = (CHANGE_CYCLES > SETTLE_CYCLES) ? CHANGE_CYCLES : SETTLE_CYCLES;
  localparam int LONGEST = (LONG_CS > DEBOUNCE_CYCLES) ? LONG_CS : DEBOUNCE_CYCLES;
  localparam int TW      = $clog2(LONGEST + 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [TW-1:0]    r_timer;
  logic [1:0]       r_tab_sync;
  logic [1:0]       r_pre_sync;
  logic             r_tab_prev;
  logic             w_tab_level;
  logic             w_tab_pulse;
  logic [BCD_W-1:0] r_tgt_tens;
  logic [BCD_W-1:0] r_tgt_ones;
  logic             r_spill;
  logic             r_change;
  logic             r_gate;
  logic             w_start_ok;
  logic             w_accept;
  logic             w_cnt_clr;
  logic             w_cnt_inc;
  logic             w_eq_target;
  logic             w_spill_set;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_tab_sync <= '0;
      r_pre_sync <= '0;
    end else begin
      r_tab_sync <= {r_tab_sync[0], i_tablet};
      r_pre_sync <= {r_pre_sync[0], i_pre_over};
    end
  end

`ifdef TABLET_DEBOUNCE_EN
  logic          r_deb_level;
  logic [TW-1:0] r_deb_cnt;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_deb_level <= 1'b0;
      r_deb_cnt   <= '0;
    end else if (r_tab_sync[1] != r_deb_level) begin
      if (r_deb_cnt == TW'(DEBOUNCE_CYCLES - 1)) begin
        r_deb_level <= r_tab_sync[1];
        r_deb_cnt   <= '0;
      end else begin
        r_deb_cnt <= r_deb_cnt + TW'(1);
      end
    end else begin
      r_deb_cnt <= '0;
    end
  end

  assign w_tab_level = r_deb_level;
`else
  assign w_tab_level = r_tab_sync[1];
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_tab_prev <= 1'b0;
    else            r_tab_prev <= w_tab_level;
  end

  assign w_tab_pulse = w_tab_level & ~r_tab_prev;
  assign w_start_ok  = i_start && bcd_valid(i_target_tens, i_target_ones);
  assign w_spill_set = w_tab_pulse && ((r_state == ST_CHANGE) || (r_state == ST_SETTLE));

  bcd2_counter u_counter (
    .i_clk       (i_clk),
    .i_rst_n     (i_reset_n),
    .i_clr       (w_cnt_clr),
    .i_inc       (w_cnt_inc),
    .i_tgt_tens  (r_tgt_tens),
    .i_tgt_ones  (r_tgt_ones),
    .o_tens      (o_tab_tens),
    .o_ones      (o_tab_ones),
    .o_eq_target (w_eq_target)
  );

  always_comb begin
    w_next_state = r_state;
    w_cnt_clr    = 1'b0;
    w_cnt_inc    = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_start_ok) begin
          w_next_state = ST_FILL;
          w_cnt_clr    = 1'b1;
          w_accept     = 1'b1;
        end
      end
      ST_FILL: begin
        if (w_tab_pulse) begin
          w_cnt_inc = 1'b1;
          if (w_eq_target) w_next_state = ST_CHANGE;
        end
      end
      ST_CHANGE: begin
        if (r_timer == TW'(CHANGE_CYCLES - 1)) w_next_state = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (r_timer == TW'(SETTLE_CYCLES - 1)) begin
          if (r_pre_sync[1]) begin
            w_next_state = ST_DONE;
          end else begin
            w_next_state = ST_FILL;
            w_cnt_clr    = 1'b1;
          end
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
    // Stop overrides everything, including a simultaneous start, and freezes the count.
    if (i_stop) begin
      w_next_state = ST_IDLE;
      w_cnt_clr    = 1'b0;
      w_cnt_inc    = 1'b0;
      w_accept     = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= ST_IDLE;
      r_timer    <= '0;
      r_tgt_tens <= '0;
      r_tgt_ones <= '0;
      r_spill    <= 1'b0;
      r_change   <= 1'b0;
      r_gate     <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if ((w_next_state != r_state) || !((r_state == ST_CHANGE) || (r_state == ST_SETTLE)))
        r_timer <= '0;
      else
        r_timer <= r_timer + TW'(1);
      if (w_accept) begin
        r_tgt_tens <= i_target_tens;
        r_tgt_ones <= i_target_ones;
      end
      if (w_accept)         r_spill <= 1'b0;
      else if (w_spill_set) r_spill <= 1'b1;
      r_change <= (w_next_state == ST_CHANGE);
      r_gate   <= (w_next_state == ST_FILL);
    end
  end

  assign o_gate_open = r_gate;
  assign o_change    = r_change;
  assign o_spill     = r_spill;
  assign o_busy      = (r_state == ST_FILL) || (r_state == ST_CHANGE) || (r_state == ST_SETTLE);
  assign o_done      = (r_state == ST_DONE);

endmodule

// File: tb/tb_tablet_fill_ctrl.sv
// Self-checking bench for tablet_fill_ctrl: vector table, directed multi-cycle
// corner sequences, and a randomized run against a behavioural reference model.
module tb_tablet_fill_ctrl;

  localparam int CHANGE_CYCLES   = 4;
  localparam int SETTLE_CYCLES   = 16;
  localparam int DEBOUNCE_CYCLES = 8;
`ifdef TABLET_DEBOUNCE_EN
  localparam int EXTRA = DEBOUNCE_CYCLES;
`else
  localparam int EXTRA = 0;
`endif
  localparam int HI = 2 + EXTRA;
  localparam int LO = 3 + EXTRA;

  localparam int M_IDLE   = 0;
  localparam int M_FILL   = 1;
  localparam int M_CHANGE = 2;
  localparam int M_SETTLE = 3;
  localparam int M_DONE   = 4;

  logic       clk = 1'b0;
  logic       rstN;
  logic       start;
  logic       stop;
  logic       tablet;
  logic       preOver;
  logic [3:0] tgtTens;
  logic [3:0] tgtOnes;
  logic [3:0] tabTens;
  logic [3:0] tabOnes;
  logic       gateOpen;
  logic       change;
  logic       busy;
  logic       done;
  logic       spill;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  tablet_fill_ctrl #(
    .CHANGE_CYCLES   (CHANGE_CYCLES),
    .SETTLE_CYCLES   (SETTLE_CYCLES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) dut (
    .i_clk         (clk),
    .i_reset_n     (rstN),
    .i_start       (start),
    .i_stop        (stop),
    .i_tablet      (tablet),
    .i_target_tens (tgtTens),
    .i_target_ones (tgtOnes),
    .i_pre_over    (preOver),
    .o_tab_tens    (tabTens),
    .o_tab_ones    (tabOnes),
    .o_gate_open   (gateOpen),
    .o_change      (change),
    .o_busy        (busy),
    .o_done        (done),
    .o_spill       (spill)
  );

  // Reference model: decimal count, phase and remaining-cycle budget, updated per clock.
  int  mPhase;
  int  mCount;
  int  mTarget;
  int  mLeft;
  bit  mSpill;
  bit  tabS0, tabS1, lvlPrev, preS0, preS1, mPreNow, mPulse, mLvl, mDeb;
  int  mRun;

  function automatic bit targetOk(input logic [3:0] t, input logic [3:0] o);
    return (int'(t) <= 9) && (int'(o) <= 9) && ((int'(t) * 10 + int'(o)) != 0);
  endfunction

  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      mPhase = M_IDLE; mCount = 0; mTarget = 0; mLeft = 0; mSpill = 0;
      tabS0 = 0; tabS1 = 0; lvlPrev = 0; preS0 = 0; preS1 = 0; mDeb = 0; mRun = 0;
    end else begin
`ifdef TABLET_DEBOUNCE_EN
      mLvl = mDeb;
      if (tabS1 != mDeb) begin
        mRun++;
        if (mRun == DEBOUNCE_CYCLES) begin
          mDeb = tabS1;
          mRun = 0;
        end
      end else begin
        mRun = 0;
      end
`else
      mLvl = tabS1;
`endif
      mPulse  = mLvl && !lvlPrev;
      lvlPrev = mLvl;
      tabS1   = tabS0;
      tabS0   = tablet;
      mPreNow = preS1;
      preS1   = preS0;
      preS0   = preOver;

      if (mPulse && (mPhase == M_CHANGE || mPhase == M_SETTLE)) mSpill = 1;
      if (stop) begin
        mPhase = M_IDLE;
      end else begin
        case (mPhase)
          M_IDLE, M_DONE: begin
            if (start && targetOk(tgtTens, tgtOnes)) begin
              mPhase  = M_FILL;
              mCount  = 0;
              mSpill  = 0;
              mTarget = int'(tgtTens) * 10 + int'(tgtOnes);
            end
          end
          M_FILL: begin
            if (mPulse) begin
              mCount++;
              if (mCount == mTarget) begin
                mPhase = M_CHANGE;
                mLeft  = CHANGE_CYCLES;
              end
            end
          end
          M_CHANGE: begin
            mLeft--;
            if (mLeft == 0) begin
              mPhase = M_SETTLE;
              mLeft  = SETTLE_CYCLES;
            end
          end
          M_SETTLE: begin
            mLeft--;
            if (mLeft == 0) begin
              if (mPreNow) begin
                mPhase = M_DONE;
              end else begin
                mPhase = M_FILL;
                mCount = 0;
              end
            end
          end
          default: mPhase = M_IDLE;
        endcase
      end
    end
  end

  function automatic logic [12:0] modelOutputs();
    logic [3:0] t, o;
    t = 4'(mCount / 10);
    o = 4'(mCount % 10);
    return {t, o, (mPhase == M_FILL), (mPhase == M_CHANGE),
            (mPhase == M_FILL || mPhase == M_CHANGE || mPhase == M_SETTLE),
            (mPhase == M_DONE), mSpill};
  endfunction

  function automatic logic [12:0] dutOutputs();
    return {tabTens, tabOnes, gateOpen, change, busy, done, spill};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  typedef struct {
    logic       start;
    logic       stop;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       expBusy;
    logic       expGate;
  } vec_t;

  vec_t vecs[12];

  task automatic applyStimulus(input vec_t v);
    start   = v.start;
    stop    = v.stop;
    tgtTens = v.tens;
    tgtOnes = v.ones;
  endtask

  task automatic doReset();
    rstN = 1'b0; start = 0; stop = 0; tablet = 0; preOver = 0; tgtTens = 0; tgtOnes = 0;
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs", 32'(dutOutputs()), 32'h0);
    rstN = 1'b1;
    @(negedge clk);
  endtask

  task automatic dropTablet(input int hi, input int lo);
    tablet = 1'b1;
    repeat (hi) @(negedge clk);
    tablet = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic pulseStart(input logic [3:0] t, input logic [3:0] o);
    tgtTens = t; tgtOnes = o; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulseStop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int changeLen;
    int tabHold;

    vecs[0]  = '{1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 4'h1, 4'hA, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 4'hA, 4'h1, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 4'h0, 4'h3, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 4'h0, 4'h3, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 4'h0, 4'h3, 1'b1, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 4'h0, 4'h1, 1'b1, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 4'h0, 4'h1, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 4'h9, 4'h9, 1'b1, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 4'h0, 4'h2, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 4'h1, 4'h0, 1'b1, 1'b1};
    vecs[11] = '{1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0};

    @(negedge clk);
    doReset();
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput($sformatf("vec%0d", i), 32'({busy, gateOpen, done, tabTens, tabOnes}),
                  32'({vecs[i].expBusy, vecs[i].expGate, 1'b0, 8'h00}));
    end
    start = 0; stop = 0;

    $display("[TB] sequence: three-tablet bottle with change and settle");
    doReset();
    pulseStart(4'd0, 4'd3);
    checkOutput("s1_gate_fill", 32'(gateOpen), 32'd1);
    dropTablet(HI, LO);
    checkOutput("s1_count1", 32'({tabTens, tabOnes}), 32'h01);
    dropTablet(HI, LO);
    checkOutput("s1_count2", 32'({tabTens, tabOnes}), 32'h02);
    tablet = 1'b1;
    repeat (HI) @(negedge clk);
    tablet = 1'b0;
    @(negedge clk);
    checkOutput("s1_count3", 32'({tabTens, tabOnes}), 32'h03);
    checkOutput("s1_gate_change", 32'({gateOpen, change}), 32'b01);
    changeLen = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!change) break;
      changeLen++;
    end
    checkOutput("s1_change_len", 32'(changeLen), 32'(CHANGE_CYCLES));
    repeat (SETTLE_CYCLES - 1) @(negedge clk);
    checkOutput("s1_settle_hold", 32'({gateOpen, busy, tabTens, tabOnes}), 32'h103);
    @(negedge clk);
    checkOutput("s1_refill", 32'({gateOpen, tabTens, tabOnes}), 32'h100);

    $display("[TB] sequence: batch limit reached");
    doReset();
    preOver = 1'b1;
    pulseStart(4'd1, 4'd2);
    repeat (12) dropTablet(HI, LO);
    repeat (CHANGE_CYCLES + SETTLE_CYCLES + 2) @(negedge clk);
    checkOutput("s2_done", 32'({done, gateOpen, busy, tabTens, tabOnes}), 32'h412);
    dropTablet(HI, LO);
    dropTablet(HI, LO);
    checkOutput("s2_done_ignore", 32'({done, spill, tabTens, tabOnes}), 32'h212);
    preOver = 1'b0;

    $display("[TB] sequence: tablet during bottle change");
    doReset();
    pulseStart(4'd0, 4'd9);
    repeat (8) dropTablet(HI, LO);
    tablet = 1'b1;
    repeat (HI) @(negedge clk);
    tablet = 1'b0;
    @(negedge clk);
    checkOutput("s3_count9", 32'({change, tabTens, tabOnes}), 32'h109);
    repeat (EXTRA) @(negedge clk);
    dropTablet(HI, LO);
    checkOutput("s3_spill", 32'({spill, tabTens, tabOnes}), 32'h109);
    pulseStop();
    checkOutput("s3_spill_sticky", 32'({spill, busy}), 32'b10);
    pulseStart(4'd0, 4'd9);
    checkOutput("s3_spill_clear", 32'({spill, busy, tabTens, tabOnes}), 32'h100);

    $display("[TB] sequence: stop during change, start with stop");
    doReset();
    pulseStart(4'd0, 4'd1);
    tablet = 1'b1;
    repeat (HI) @(negedge clk);
    tablet = 1'b0;
    @(negedge clk);
    checkOutput("s4_change_c1", 32'(change), 32'd1);
    @(negedge clk);
    checkOutput("s4_change_c2", 32'(change), 32'd1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    checkOutput("s4_stop", 32'({change, gateOpen, busy, tabTens, tabOnes}), 32'h001);
    tgtTens = 4'd0; tgtOnes = 4'd3; start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    checkOutput("s4_start_stop", 32'({busy, gateOpen, done}), 32'd0);

    $display("[TB] sequence: async reset mid-fill");
    doReset();
    pulseStart(4'd0, 4'd9);
    repeat (5) dropTablet(HI, LO);
    checkOutput("s5_count5", 32'({busy, tabTens, tabOnes}), 32'h105);
    #2 rstN = 1'b0;
    #1 checkOutput("s5_async_reset", 32'(dutOutputs()), 32'h0);
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);

`ifdef TABLET_DEBOUNCE_EN
    $display("[TB] sequence: debounce glitch rejection");
    doReset();
    pulseStart(4'd0, 4'd9);
    tablet = 1'b1;
    repeat (3) @(negedge clk);
    tablet = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("s6_glitch", 32'({tabTens, tabOnes}), 32'h00);
    tablet = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("s6_not_yet", 32'({tabTens, tabOnes}), 32'h00);
    tablet = 1'b0;
    @(negedge clk);
    checkOutput("s6_one", 32'({tabTens, tabOnes}), 32'h01);
    repeat (20) @(negedge clk);
`endif

    $display("[TB] randomized run against reference model");
    doReset();
    tabHold = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      checkOutput($sformatf("rand_cyc%0d", cyc), 32'(dutOutputs()), 32'(modelOutputs()));
      start = ($urandom_range(15) == 0);
      stop  = ($urandom_range(399) == 0);
      if (tabHold == 0) begin
        tablet  = ~tablet;
        tabHold = $urandom_range(4, 1);
      end else begin
        tabHold--;
      end
      if ($urandom_range(9) == 0) begin
        tgtTens = 4'($urandom_range(15));
        tgtOnes = 4'($urandom_range(15));
      end else begin
        tgtTens = 4'($urandom_range(2));
        tgtOnes = 4'($urandom_range(9));
      end
      if ($urandom_range(39) == 0) preOver = ~preOver;
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
